// File: rtl/mii_io_tx_rate.sv
// PHY-side MII transmit capture with 10/100 rate select.
// Divides clk into tx_clk, samples tx_en/tx_er/txd once per tx_clk period and strobes them out.
module mii_io_tx_rate #(
    parameter int DATA_WIDTH = 4,
    parameter int DIV        = 5,
    parameter int SLOW_MULT  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  speed_10_i,
    output logic                  speed_o,
    output logic                  ce_o,
    output logic                  enable_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic                  tx_clk_o,
    input  logic                  tx_en_i,
    input  logic                  tx_er_i,
    input  logic [DATA_WIDTH-1:0] txd_i
);

    localparam int P_FAST = DIV;
    localparam int P_SLOW = DIV * SLOW_MULT;
    localparam int CW     = (P_SLOW > 2) ? $clog2(P_SLOW) : 1;

    localparam logic [CW-1:0] LOAD_FAST = CW'(P_FAST - 1);
    localparam logic [CW-1:0] LOAD_SLOW = CW'(P_SLOW - 1);
    localparam logic [CW-1:0] HALF_FAST = CW'(P_FAST / 2);
    localparam logic [CW-1:0] HALF_SLOW = CW'(P_SLOW / 2);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  speed_q, speed_d;
    logic                  tx_clk_q, tx_clk_d;
    logic                  ce_q, ce_d;
    logic                  enable_q, enable_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sof_q, sof_d;
    logic                  eof_q, eof_d;
    logic                  init_q;
    logic                  rate_ok;

    // A rate change is only safe between frames: nothing captured and nothing arriving.
    assign rate_ok = (speed_10_i != speed_q) && !enable_q && !tx_en_i;

    always_comb begin
        cnt_d    = cnt_q;
        speed_d  = speed_q;
        ce_d     = 1'b0;
        enable_d = enable_q;
        err_d    = err_q;
        data_d   = data_q;
        sof_d    = 1'b0;
        eof_d    = 1'b0;

        if (init_q) begin
            // First cycle out of reset restarts the period with no sample pending.
            cnt_d = LOAD_FAST;
        end else if (cnt_q == '0) begin
            if (rate_ok) begin
                speed_d = speed_10_i;
            end
            cnt_d    = speed_d ? LOAD_SLOW : LOAD_FAST;
            ce_d     = 1'b1;
            enable_d = tx_en_i;
            err_d    = tx_er_i;
            data_d   = txd_i;
            sof_d    = tx_en_i && !enable_q;
            eof_d    = !tx_en_i && enable_q;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end

        // tx_clk is registered from the next count, so it tracks the k-rule with no glitch.
        tx_clk_d = (cnt_d >= (speed_d ? HALF_SLOW : HALF_FAST));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= LOAD_FAST;
            speed_q  <= 1'b0;
            tx_clk_q <= 1'b0;
            ce_q     <= 1'b0;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            init_q   <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            speed_q  <= speed_d;
            tx_clk_q <= tx_clk_d;
            ce_q     <= ce_d;
            enable_q <= enable_d;
            err_q    <= err_d;
            data_q   <= data_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            init_q   <= 1'b0;
        end
    end

    assign speed_o  = speed_q;
    assign tx_clk_o = tx_clk_q;
    assign ce_o     = ce_q;
    assign enable_o = enable_q;
    assign err_o    = err_q;
    assign data_o   = data_q;
    assign sof_o    = sof_q;
    assign eof_o    = eof_q;

endmodule

// File: tb/tb_mii_io_tx_rate.sv
// Directed bench for mii_io_tx_rate: idle timing, frame capture, rate change, deferral, reset.
// Cycle numbering: cyc 0 is the first cycle after the reset-state cycle in which rst is low.
module tb_mii_io_tx_rate;

    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          speed_10;
    logic          speed;
    logic          ce;
    logic          enable;
    logic          err;
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
    logic          tx_clk;
    logic          tx_en;
    logic          tx_er;
    logic [DW-1:0] txd;

    int cyc;
    int n_tests;
    int n_fail;

    mii_io_tx_rate #(
        .DATA_WIDTH(DW),
        .DIV       (5),
        .SLOW_MULT (10)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .speed_10_i(speed_10),
        .speed_o   (speed),
        .ce_o      (ce),
        .enable_o  (enable),
        .err_o     (err),
        .data_o    (data),
        .sof_o     (sof),
        .eof_o     (eof),
        .tx_clk_o  (tx_clk),
        .tx_en_i   (tx_en),
        .tx_er_i   (tx_er),
        .txd_i     (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_speed"},  32'(speed),  32'd0);
        check({tag, "_txclk"},  32'(tx_clk), 32'd0);
        check({tag, "_ce"},     32'(ce),     32'd0);
        check({tag, "_enable"}, 32'(enable), 32'd0);
        check({tag, "_err"},    32'(err),    32'd0);
        check({tag, "_sof"},    32'(sof),    32'd0);
        check({tag, "_eof"},    32'(eof),    32'd0);
        check({tag, "_data"},   32'(data),   32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tx_en    = 1'b0;
        tx_er    = 1'b0;
        txd      = '0;
        speed_10 = 1'b0;
        step();
        step();
        check_zero("rst");
        rst = 1'b0;
        step();
        cyc = 0;
    endtask

    // 100M idle pattern: tx_clk 1,1,1,0,0 and ce every fifth cycle from cycle 5.
    task automatic check_fast_idle(input string tag);
        check({tag, "_txclk"}, 32'(tx_clk), 32'((cyc % 5) < 3));
        check({tag, "_ce"},    32'(ce),     32'((cyc > 0) && (cyc % 5 == 0)));
        check({tag, "_sof"},   32'(sof),    32'd0);
        check({tag, "_eof"},   32'(eof),    32'd0);
    endtask

    initial begin
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        rst      = 1'b1;
        tx_en    = 1'b0;
        tx_er    = 1'b0;
        txd      = '0;
        speed_10 = 1'b0;

        // Idle timing after reset
        do_reset();
        check_fast_idle("idle");
        repeat (14) begin
            step();
            check_fast_idle("idle");
        end

        // Frame capture A,B,C,D then end of frame with tx_er alone, then deferred rate change
        do_reset();
        while (cyc < 9) step();
        tx_en = 1'b1;
        txd   = 4'hA;
        while (cyc < 104) begin
            step();
            case (cyc)
                14: txd = 4'hB;
                19: txd = 4'hC;
                24: txd = 4'hD;
                29: begin tx_en = 1'b0; tx_er = 1'b1; txd = 4'h0; end
                34: tx_er = 1'b0;
                39: begin tx_en = 1'b1; txd = 4'h5; end
                41: speed_10 = 1'b1;
                49: tx_en = 1'b0;
                default: ;
            endcase
            if (cyc == 10) begin
                check("sof_ce",     32'(ce),     32'd1);
                check("sof_data",   32'(data),   32'hA);
                check("sof_enable", 32'(enable), 32'd1);
                check("sof_pulse",  32'(sof),    32'd1);
            end
            if (cyc >= 11 && cyc <= 14) begin
                check("hold_data", 32'(data), 32'hA);
                check("hold_ce",   32'(ce),   32'd0);
                check("hold_sof",  32'(sof),  32'd0);
            end
            if (cyc == 15) check("nib_b", 32'(data), 32'hB);
            if (cyc == 20) check("nib_c", 32'(data), 32'hC);
            if (cyc == 25) begin
                check("nib_d",     32'(data), 32'hD);
                check("nib_d_sof", 32'(sof),  32'd0);
            end
            if (cyc == 30) begin
                check("eof_ce",     32'(ce),     32'd1);
                check("eof_pulse",  32'(eof),    32'd1);
                check("eof_enable", 32'(enable), 32'd0);
                check("eof_err",    32'(err),    32'd1);
            end
            if (cyc == 31) begin
                check("eof_width", 32'(eof), 32'd0);
                check("err_hold",  32'(err), 32'd1);
            end
            if (cyc == 35) check("err_clear", 32'(err), 32'd0);
            if (cyc == 40) check("sof2", 32'(sof), 32'd1);
            if (cyc >= 41 && cyc <= 54) begin
                check("defer_speed", 32'(speed),  32'd0);
                check("defer_txclk", 32'(tx_clk), 32'((cyc % 5) < 3));
                check("defer_ce",    32'(ce),     32'(cyc % 5 == 0));
            end
            if (cyc == 50) check("defer_eof", 32'(eof), 32'd1);
            if (cyc == 55) begin
                check("switch_speed", 32'(speed),  32'd1);
                check("switch_ce",    32'(ce),     32'd1);
                check("switch_txclk", 32'(tx_clk), 32'd1);
            end
            if (cyc >= 56 && cyc <= 104) begin
                check("slow_txclk", 32'(tx_clk), 32'(cyc < 80));
                check("slow_ce",    32'(ce),     32'd0);
                check("slow_speed", 32'(speed),  32'd1);
            end
        end

        // Mid-frame reset at 10M
        step();
        check("slow_ce105", 32'(ce), 32'd1);
        tx_en = 1'b1;
        txd   = 4'h7;
        while (cyc < 158) begin
            step();
            if (cyc == 155) begin
                check("slow_sof",   32'(sof),   32'd1);
                check("slow_data",  32'(data),  32'h7);
                check("slow_speed", 32'(speed), 32'd1);
            end
        end
        check("pre_rst_txclk", 32'(tx_clk), 32'd1);
        rst = 1'b1;
        step();
        check_zero("midrst");
        rst      = 1'b0;
        tx_en    = 1'b0;
        txd      = '0;
        speed_10 = 1'b0;
        step();
        cyc = 0;
        check_fast_idle("resume");
        repeat (10) begin
            step();
            check_fast_idle("resume");
        end

        // Idle rate change: speed_10 from cycle 2, 50-cycle period from cycle 5
        do_reset();
        while (cyc < 2) step();
        speed_10 = 1'b1;
        check("rc_speed_early", 32'(speed), 32'd0);
        while (cyc < 105) begin
            step();
            if (cyc == 60) speed_10 = 1'b0;
            if (cyc == 61) speed_10 = 1'b1;
            if (cyc < 5) begin
                check("rc_speed_pre", 32'(speed), 32'd0);
            end else begin
                check("rc_speed", 32'(speed), 32'd1);
                check("rc_ce", 32'(ce), 32'((cyc == 5) || (cyc == 55) || (cyc == 105)));
                if (cyc < 105)
                    check("rc_txclk", 32'(tx_clk), 32'(((cyc - 5) % 50) < 25));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
